// File: rtl/r200_pkg.sv
// Shared encodings for the r200 execute unit: ALU, branch and M-extension
// func3 values plus the execute FSM state constants.
package r200_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_MUL  = 2'b01;
    localparam state_t ST_DIV  = 2'b10;
    localparam state_t ST_DONE = 2'b11;

endpackage

// File: rtl/r200_muldiv_iter.sv
// Iterative M-extension engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with the sign fix-up applied on readout.
module r200_muldiv_iter
    import r200_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [2:0]      func3,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   hi_r, lo_r, b_r;
    logic [2:0]        func3_r;
    logic              is_div_r, neg_r, rem_neg_r;

    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [2*XLEN-1:0] step_in_s, step_out_s, prod_fix_s;
    logic [XLEN-1:0]   dvs_s, quo_fix_s, rem_fix_s;
    logic              mode_div_s;

    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] prod,
                                                    input logic [XLEN-1:0]   mcand);
        logic [XLEN:0] sum;
        sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        return {sum, prod[XLEN-1:1]};
    endfunction

    // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] rq,
                                                    input logic [XLEN-1:0]   dvs);
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sh   = {rq[2*XLEN-1:XLEN], rq[XLEN-1]};
        diff = sh - {1'b0, dvs};
        if (!diff[XLEN]) begin
            return {diff[XLEN-1:0], rq[XLEN-2:0], 1'b1};
        end else begin
            return {sh[XLEN-1:0], rq[XLEN-2:0], 1'b0};
        end
    endfunction

    assign a_neg_s = (func3 != M_MULHU) && (func3 != M_DIVU) && (func3 != M_REMU) && op_a[XLEN-1];
    assign b_neg_s = ((func3 == M_MUL) || (func3 == M_MULH) || (func3 == M_DIV) ||
                      (func3 == M_REM)) && op_b[XLEN-1];
    assign a_mag_s = a_neg_s ? -op_a : op_a;
    assign b_mag_s = b_neg_s ? -op_b : op_b;

    // The first iteration is folded into the start cycle so XLEN steps end in DONE on time.
    assign step_in_s  = start ? {{XLEN{1'b0}}, a_mag_s} : {hi_r, lo_r};
    assign dvs_s      = start ? b_mag_s : b_r;
    assign mode_div_s = start ? func3[2] : is_div_r;
    assign step_out_s = mode_div_s ? div_step(step_in_s, dvs_s) : mul_step(step_in_s, dvs_s);

    assign done = step && (cnt_r == LAST_CNT);

    // Iteration state: counter, working registers and captured sign/mode flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            func3_r   <= 3'b000;
            is_div_r  <= 1'b0;
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
        end else if (flush) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (start) begin
            cnt_r        <= CNT_ONE;
            {hi_r, lo_r} <= step_out_s;
            b_r          <= b_mag_s;
            func3_r      <= func3;
            is_div_r     <= func3[2];
            neg_r        <= a_neg_s ^ b_neg_s;
            rem_neg_r    <= a_neg_s;
        end else if (step) begin
            cnt_r        <= cnt_r + CNT_ONE;
            {hi_r, lo_r} <= step_out_s;
        end
    end

    assign prod_fix_s = neg_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    assign quo_fix_s  = neg_r ? -lo_r : lo_r;
    assign rem_fix_s  = rem_neg_r ? -hi_r : hi_r;

    // Select the architectural result for the captured operation.
    always_comb begin
        result = {XLEN{1'b0}};
        case (func3_r)
            M_MUL:                      result = prod_fix_s[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU:  result = prod_fix_s[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:              result = quo_fix_s;
            M_REM, M_REMU:              result = rem_fix_s;
            default:                    result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/r200_exu.sv
// Handshaked execute stage: single-cycle ALU/branch/jump-target with a
// registered output, plus an iterative mul/div that stalls the input side.
module r200_exu
    import r200_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      func3,
    input  logic            alu_cont,
    input  logic            is_muldiv,
    input  logic            is_branch,
    input  logic [XLEN-1:0] jump_imm,
    input  logic [XLEN-1:0] jump_addimm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] pc_jumptarg,
    output logic            willbr,
    output logic            busy
);

    localparam int              SH_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_r;
    logic            out_valid_r, willbr_r;
    logic [XLEN-1:0] result_r, pc_jumptarg_r;

    logic            in_ready_s, accept_s, taken_s, special_s, md_start_s, md_done_s;
    logic [SH_W-1:0] shamt_s;
    logic [XLEN-1:0] alu_res_s, sra_s, jt_s, special_res_s, md_result_s;

    assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !flush;
    assign accept_s   = in_valid && in_ready_s;
    assign shamt_s    = op2[SH_W-1:0];
    assign sra_s      = $signed(op1) >>> shamt_s;
    assign jt_s       = jump_imm + jump_addimm;

    // Integer ALU.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (func3)
            ALU_ADD:  alu_res_s = alu_cont ? (op1 - op2) : (op1 + op2);
            ALU_SLL:  alu_res_s = op1 << shamt_s;
            ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  alu_res_s = op1 ^ op2;
            ALU_SR:   alu_res_s = alu_cont ? sra_s : (op1 >> shamt_s);
            ALU_OR:   alu_res_s = op1 | op2;
            ALU_AND:  alu_res_s = op1 & op2;
            default:  alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Branch comparator.
    always_comb begin
        taken_s = 1'b0;
        case (func3)
            BR_EQ:   taken_s = (op1 == op2);
            BR_NE:   taken_s = (op1 != op2);
            BR_LT:   taken_s = ($signed(op1) < $signed(op2));
            BR_GE:   taken_s = ($signed(op1) >= $signed(op2));
            BR_LTU:  taken_s = (op1 < op2);
            BR_GEU:  taken_s = (op1 >= op2);
            default: taken_s = 1'b0;
        endcase
    end

    // Divide-by-zero and signed overflow finish immediately without the iterator.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = {XLEN{1'b0}};
        if (is_muldiv && func3[2] && (op2 == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_res_s = func3[1] ? op1 : {XLEN{1'b1}};
        end else if (is_muldiv && func3[2] && !func3[0] && (op1 == INT_MIN) &&
                     (op2 == {XLEN{1'b1}})) begin
            special_s     = 1'b1;
            special_res_s = func3[1] ? {XLEN{1'b0}} : op1;
        end else begin
            special_s     = 1'b0;
            special_res_s = {XLEN{1'b0}};
        end
    end

    assign md_start_s = accept_s && is_muldiv && !special_s;

    r200_muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (md_start_s),
        .step   (busy),
        .op_a   (op1),
        .op_b   (op2),
        .func3  (func3),
        .done   (md_done_s),
        .result (md_result_s)
    );

    // FSM and output register; flush wins over completion in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            out_valid_r   <= 1'b0;
            result_r      <= {XLEN{1'b0}};
            pc_jumptarg_r <= {XLEN{1'b0}};
            willbr_r      <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        pc_jumptarg_r <= jt_s;
                        if (md_start_s) begin
                            willbr_r <= 1'b0;
                            state_r  <= func3[2] ? ST_DIV : ST_MUL;
                        end else begin
                            result_r    <= is_muldiv ? special_res_s : alu_res_s;
                            willbr_r    <= !is_muldiv && is_branch && taken_s;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_r || out_ready) begin
                        result_r    <= md_result_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign pc_jumptarg = pc_jumptarg_r;
    assign willbr      = willbr_r;
    assign busy        = (state_r == ST_MUL) || (state_r == ST_DIV);

endmodule

// File: tb/tb_r200_exu.sv
// Self-checking bench for r200_exu: directed vector table, hand-written
// stall/flush/reset sequences and randomized ops against an arithmetic model.
module tb_r200_exu;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op1, op2, jump_imm, jump_addimm, result, pc_jumptarg;
    logic [2:0]  func3;
    logic        alu_cont, is_muldiv, is_branch, willbr, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    r200_exu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .func3(func3), .alu_cont(alu_cont), .is_muldiv(is_muldiv),
        .is_branch(is_branch), .jump_imm(jump_imm), .jump_addimm(jump_addimm),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .pc_jumptarg(pc_jumptarg), .willbr(willbr), .busy(busy)
    );

    typedef struct {
        logic [31:0] op1, op2;
        logic [2:0]  f3;
        logic        ac, md, br;
        logic [31:0] imm, addimm;
        logic [31:0] exp_res;
        logic        exp_wb;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                input logic ac, input logic md, input logic br,
                                input logic [31:0] imm, input logic [31:0] addimm,
                                input logic [31:0] res, input logic wb, input int lat);
        vec_t v;
        v.op1 = a; v.op2 = b; v.f3 = f3; v.ac = ac; v.md = md; v.br = br;
        v.imm = imm; v.addimm = addimm; v.exp_res = res; v.exp_wb = wb; v.exp_lat = lat;
        return v;
    endfunction

    // Reference model straight from the ISA definitions.
    function automatic logic [31:0] ref_res(input vec_t v);
        logic [63:0] p;
        logic [31:0] a, b;
        int sa, sb, sh;
        logic ovf;
        a = v.op1; b = v.op2; sa = a; sb = b; sh = int'(b[4:0]);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (v.md) begin
            case (v.f3)
                3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
                3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
                3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
                3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
                3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
                3'd6: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
                default: return (b == 32'd0) ? a : a % b;
            endcase
        end
        case (v.f3)
            3'd0: return v.ac ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return v.ac ? 32'(sa >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_wb(input vec_t v);
        int sa, sb;
        sa = v.op1; sb = v.op2;
        if (!v.br || v.md) return 1'b0;
        case (v.f3)
            3'd0: return v.op1 == v.op2;
            3'd1: return v.op1 != v.op2;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return v.op1 < v.op2;
            3'd7: return v.op1 >= v.op2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_lat(input vec_t v);
        if (!v.md) return 1;
        if (v.f3 >= 3'd4 && v.op2 == 32'd0) return 1;
        if ((v.f3 == 3'd4 || v.f3 == 3'd6) && v.op1 == 32'h8000_0000 && v.op2 == 32'hFFFF_FFFF)
            return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input vec_t v);
        op1 = v.op1; op2 = v.op2; func3 = v.f3; alu_cont = v.ac; is_muldiv = v.md;
        is_branch = v.br; jump_imm = v.imm; jump_addimm = v.addimm; in_valid = 1'b1;
    endtask

    // Present one op, wait for its result, check latency/values and optional hold.
    task automatic run_op(input vec_t v, input int hold, input string tag);
        int wait_n, lat;
        logic win_bad, hold_bad;
        logic [31:0] exp_jt;
        exp_jt = v.imm + v.addimm;
        @(negedge clk);
        drive(v);
        out_ready = (hold == 0);
        #1;
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin @(negedge clk); #1; wait_n++; end
        chk({tag, "_accept"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; win_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (v.exp_lat > 1 && (in_ready || (lat < v.exp_lat - 1 && !busy))) win_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, v.exp_lat);
        chk({tag, "_res"}, result, v.exp_res);
        chk({tag, "_jt"}, pc_jumptarg, exp_jt);
        chk({tag, "_wb"}, willbr, v.exp_wb);
        if (v.exp_lat > 1) chk({tag, "_busywin"}, win_bad, 1'b0);
        if (hold > 0) begin
            hold_bad = 1'b0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!out_valid || result !== v.exp_res || in_ready) hold_bad = 1'b1;
            end
            chk({tag, "_hold"}, hold_bad, 1'b0);
            out_ready = 1'b1;
        end
    endtask

    vec_t tbl[16];
    vec_t v;
    logic bad;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = 32'd0; op2 = 32'd0; func3 = 3'd0; alu_cont = 1'b0; is_muldiv = 1'b0;
        is_branch = 1'b0; jump_imm = 32'd0; jump_addimm = 32'd0;

        tbl[0]  = mk(32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 1);
        tbl[1]  = mk(32'd5, 32'd7, 3'd0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd8, 32'hFFFF_FFFE, 1'b0, 1);
        tbl[2]  = mk(32'd1, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h100, 32'hFFFF_FFFF, 1'b1, 1);
        tbl[3]  = mk(32'd1, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h100, 32'hFFFF_FFFE, 1'b0, 1);
        tbl[4]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0, 1'b1, 1'b0, 32'd16, 32'd16, 32'h0, 1'b0, 33);
        tbl[5]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, 33);
        tbl[6]  = mk(32'd7, 32'd0, 3'd4, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        tbl[7]  = mk(32'd7, 32'd0, 3'd6, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd7, 1'b0, 1);
        tbl[8]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 1);
        tbl[9]  = mk(32'hFFFF_FFF9, 32'd2, 3'd4, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFD, 1'b0, 33);
        tbl[10] = mk(32'hFFFF_FFF9, 32'd2, 3'd6, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        tbl[11] = mk(32'h8000_0000, 32'h24, 3'd5, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'hF800_0000, 1'b0, 1);
        tbl[12] = mk(32'd1, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1);
        tbl[13] = mk(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1);
        tbl[14] = mk(32'h64, 32'd0, 3'd7, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h64, 1'b0, 1);
        tbl[15] = mk(32'hFFFF_FFFD, 32'd7, 3'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFEB, 1'b0, 33);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_jt", pc_jumptarg, 32'd0);
        chk("rst_willbr", willbr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 16; i++) run_op(tbl[i], (i % 4 == 3) ? 2 : 0, $sformatf("vec%0d", i));

        // Output held for five cycles while the next op waits, then accepted on release.
        @(negedge clk);
        drive(mk(32'd10, 32'd20, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1));
        out_ready = 1'b1;
        @(negedge clk);
        drive(mk(32'hF0F0, 32'h00FF, 3'd4, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1));
        out_ready = 1'b0;
        #1;
        chk("hold_first", result, 32'd30);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (!out_valid || result !== 32'd30 || in_ready) bad = 1'b1;
        end
        chk("hold_stable", bad, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("hold_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("hold_next_valid", out_valid, 1'b1);
        chk("hold_next_res", result, 32'hF00F);

        // Back-to-back single-cycle ops.
        @(negedge clk);
        drive(mk(32'd1, 32'd2, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1));
        #1;
        chk("b2b_rdy0", in_ready, 1'b1);
        @(negedge clk);
        chk("b2b_res0", result, 32'd3);
        drive(mk(32'd9, 32'd4, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1));
        #1;
        chk("b2b_rdy1", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("b2b_valid1", out_valid, 1'b1);
        chk("b2b_res1", result, 32'd5);

        // Flush at iteration 10 of a DIVU.
        @(negedge clk);
        drive(mk(32'd1000, 32'd3, 3'd5, 1'b0, 1'b1, 1'b0, 32'h40, 32'h1000, 32'd0, 1'b0, 1));
        #1;
        chk("fl_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        drive(mk(32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1));
        flush = 1'b1;
        #1;
        chk("fl_busy_before", busy, 1'b1);
        chk("fl_noaccept", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_busy", busy, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        bad = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) bad = 1'b1; end
        chk("fl_norise", bad, 1'b0);
        run_op(mk(32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd7, 1'b0, 1), 0, "fl_add");

        // Reset at iteration 10 of a DIVU.
        @(negedge clk);
        drive(mk(32'd500, 32'd7, 3'd5, 1'b0, 1'b1, 1'b0, 32'd4, 32'd8, 32'd0, 1'b0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_result", result, 32'd0);
        chk("rs_jt", pc_jumptarg, 32'd0);
        chk("rs_willbr", willbr, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_in_ready", in_ready, 1'b1);
        bad = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) bad = 1'b1; end
        chk("rs_norise", bad, 1'b0);
        run_op(mk(32'd11, 32'd6, 3'd0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'd5, 1'b0, 1), 0, "rs_sub");

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            v.op1 = pick(); v.op2 = pick();
            v.f3 = 3'($urandom_range(0, 7));
            v.ac = 1'($urandom_range(0, 1));
            v.md = ($urandom_range(0, 2) == 0);
            v.br = !v.md && ($urandom_range(0, 2) == 0);
            v.imm = $urandom(); v.addimm = $urandom();
            v.exp_res = ref_res(v);
            v.exp_wb  = ref_wb(v);
            v.exp_lat = ref_lat(v);
            run_op(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/r200_exu.md
Name: r200_exu

Overview:
- Parametrised, handshaked successor to the single-cycle execute stage.
- Performs the same integer ALU, branch-compare and jump-target functions, generalised to XLEN, with a registered output.
- Adds an iterative multiply/divide unit (RV M-extension semantics) that takes multiple cycles.
- Sits between decode/operand-fetch and memory/writeback; stalls upstream via valid/ready while a mul/div is in flight.

Parameters:
- XLEN, 32, datapath width for operands, result and jump target; must be a power of 2, at least 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  aborts any in-flight op and drops a pending output.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept this cycle.
- op1  in  XLEN  rs1 / first operand.
- op2  in  XLEN  rs2 or immediate.
- func3  in  3  instr[14:12].
- alu_cont  in  1  instr[30]: SUB/SRA select.
- is_muldiv  in  1  op is M-extension (func7 == 0000001).
- is_branch  in  1  op is conditional branch.
- jump_imm  in  XLEN  sign-extended branch/jump immediate.
- jump_addimm  in  XLEN  base added to immediate (PC or rs1).
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- result  out  XLEN  ALU or mul/div result.
- pc_jumptarg  out  XLEN  jump_imm + jump_addimm, modulo 2^XLEN.
- willbr  out  1  branch taken; forced 0 when is_branch was 0.
- busy  out  1  mul/div iteration in progress.

Behaviour:
- Reset: state IDLE; out_valid=0; result, pc_jumptarg and willbr=0; busy=0; counter=0.
- Accept: a transfer occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- ALU func3 encoding: 000 ADD/SUB (alu_cont); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA (alu_cont); 110 OR; 111 AND.
  - Shift amount is op2[$clog2(XLEN)-1:0].
  - SLT and SLTU return 0 or 1 zero-extended.
- Branch func3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010 and 011 give willbr=0.
- Single-cycle ops (!is_muldiv): result, pc_jumptarg and willbr are registered. Accepted in cycle N gives out_valid in cycle N+1. Back-to-back acceptance at one op per cycle is allowed when out_ready=1.
- M func3: 000 MUL (low), 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM: IDLE -> MUL or DIV on an accepted is_muldiv; MUL/DIV -> DONE after XLEN iterations; DONE -> IDLE when the result is loaded into the output register (same cycle).
  - Accepted in cycle N gives out_valid first high in cycle N+XLEN+1.
  - busy=1 in MUL and DIV.
- Multiply:
  - Radix-2 shift-add on operand magnitudes over a 2·XLEN product.
  - The product is negated at the end when the operand signs differ (signed modes only).
- Divide:
  - Restoring algorithm on magnitudes.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- Divide boundary cases complete in 1 cycle, bypassing the FSM, latency as single-cycle ops:
  - Divide by zero: quotient = all ones; remainder = op1.
  - Signed overflow (op1 = 1 followed by XLEN-1 zeros, op2 = all ones): quotient = op1; remainder = 0.
- Mul/div ops: pc_jumptarg is still computed and registered; willbr=0.
- Output hold: while out_valid && !out_ready, result, pc_jumptarg and willbr are stable and no new result overwrites them. The FSM waits in DONE.
- Flush:
  - Next cycle state=IDLE, out_valid=0, busy=0.
  - An op presented in the flush cycle is not accepted (in_ready=0).
  - Flush has priority over completion in the same cycle.
- Reset mid-iteration: identical to flush, plus the output registers are cleared.
- Simultaneous out_ready and in_valid in the cycle out_valid is high: the old result retires and the new op is accepted in the same cycle.

Decomposition:
- Shared package r200_pkg:
  - ALU func3 localparams.
  - Branch func3 localparams.
  - M func3 localparams.
  - FSM state enum (IDLE, MUL, DIV, DONE).
- Natural sub-module: r200_muldiv_iter.
  - Owns the counter, partial product / remainder registers and sign fix-up.
  - start/done interface toward r200_exu.
- ALU, compare and jump-target logic stay combinational inside r200_exu.

Test Plan (XLEN=32):
- ADD 0x7FFFFFFF+1, out_ready=1 -> result 0x80000000 in cycle N+1; SUB (alu_cont=1) 5-7 -> 0xFFFFFFFE.
- BLTU with op1=1, op2=0xFFFFFFFF, jump_imm=-8, jump_addimm=0x100 -> willbr=1, pc_jumptarg=0xF8; same operands with BLT -> willbr=0.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; out_valid at N+33, in_ready=0 in N+1..N+32.
- DIV 7/0 -> 0xFFFFFFFF, REM -> 7, DIV 0x80000000/-1 -> 0x80000000, each at N+1; DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF.
- out_ready=0 for 5 cycles after an ADD result -> result stable, in_ready=0; next op accepted in the cycle out_ready returns to 1.
- Flush at iteration 10 of DIVU -> out_valid never rises for it; in_ready=1 next cycle; following ADD completes normally. Same with rst=1 -> all outputs 0.
